rx_ctrl_unit: RTL and testbench
===============================

// Module: rx_ctrl_unit
// PURPOSE
//  Receive control unit for the USB receiver. Sequences the NRZI decode datapath
//  once a packet starts: enables the bit timer, deserialises decoded bits LSB-first,
//  checks the SYNC byte and writes each payload byte to the RX FIFO. Also tracks
//  EOP and flags framing, overflow and length errors. Sits between the
//  decode/edge/eop/timer blocks and the RX FIFO.
// PARAMETERS
//  SYNC_BYTE  8'h80  required first byte (wire order 0000_0001, LSB-first)
//  MAX_BYTES  64     max payload bytes per packet; one more is an error
//  CNT_W      7      width of byte_count; must hold MAX_BYTES
// PORTS
//  clk           in   1      system clock
//  rst           in   1      reset, synchronous, active-high
//  d_edge        in   1      1-cycle pulse, line transition detected
//  d_orig        in   1      decoded data bit, valid when shift_enable=1
//  shift_enable  in   1      1-cycle bit-sample strobe from timer; strobes >=2 cycles apart
//  eop           in   1      level, SE0 present on the bus
//  fifo_full     in   1      RX FIFO cannot accept a write
//  rcving        out  1      packet reception in progress
//  timer_en      out  1      enables the bit timer
//  w_enable      out  1      1-cycle FIFO write strobe
//  rx_data       out  8      last completed byte; stable while w_enable=1
//  r_error       out  1      sticky error flag
//  byte_count    out  CNT_W  payload bytes written in the current packet
// BEHAVIOUR
//  Reset: state=IDLE; rcving, timer_en, w_enable, r_error = 0; rx_data = 0;
//    byte_count = 0; bit_cnt = 0; shift reg = 0. rst mid-packet aborts with no write.
//  Shift: in SYNC, RX or WRITE, each shift_enable with eop=0 does
//    sr <= {d_orig, sr[7:1]} and bit_cnt <= bit_cnt+1 (mod 8).
//    Byte complete = shift_enable & !eop & bit_cnt==7. Decisions use the
//    combinational next-sr value.
//  States:
//   IDLE     outputs idle. d_edge -> SYNC: clear r_error, byte_count, bit_cnt.
//            d_edge is ignored in every other state.
//   SYNC     rcving=1, timer_en=1. On byte complete: next-sr==SYNC_BYTE -> RX,
//            else -> ERR. shift_enable & eop -> ERR (EOP before SYNC).
//   RX       rcving=1, timer_en=1. On byte complete: rx_data <= next-sr.
//            Then: fifo_full=1 or byte_count==MAX_BYTES -> ERR; else -> WRITE.
//            shift_enable & eop: bit_cnt==0 -> EOPW, else -> ERR (partial byte).
//   WRITE    w_enable=1 for exactly 1 cycle; byte_count++; -> RX.
//            A shift_enable in this cycle is still shifted.
//   EOPW     rcving=1, timer_en=1. shift_enable & !eop (EOP over) -> IDLE.
//   ERR      r_error <= 1, rcving=1, timer_en=1; no writes. eop=1 -> ERRW.
//   ERRW     r_error=1. shift_enable & !eop -> IDLE.
//  r_error stays 1 in IDLE until the next d_edge.
//  Latency: w_enable asserts exactly 1 cycle after the strobe that sampled bit 8.
//  rcving/timer_en drop the cycle after the IDLE transition.
//  byte_count saturates by construction (write blocked at MAX_BYTES).
//  fifo_full is sampled only at byte complete; it is not re-checked in WRITE.
// TESTING
//  1 d_edge; bits 0000_0001; bytes A5,3C; eop at bit_cnt 0 -> two w_enable pulses,
//    rx_data A5 then 3C, byte_count=2, r_error=0, rcving=0 after EOP ends.
//  2 SYNC bits giving 8'h81; later eop -> no w_enable, r_error=1 held in IDLE;
//    next d_edge clears it.
//  3 SYNC, byte 5A, 3 bits, then eop -> one write (5A), byte_count=1, r_error=1.
//  4 SYNC, fifo_full=1 at completion of byte 11 -> no w_enable, r_error=1, ERR until EOP.
//  5 MAX_BYTES=2, SYNC + bytes 01,02,03 -> writes 01,02 only; r_error=1 on third byte.
//  6 rst=1 in RX between strobes -> next cycle all outputs 0, IDLE;
//    d_edge pulses in RX/WRITE cause no state change.

Source files
------------

// File: rtl/rx_ctrl_unit.sv
// rx_ctrl_unit: USB receive sequencer (sync check, LSB-first deserialise, FIFO writes, EOP/error tracking)
module rx_ctrl_unit #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int MAX_BYTES = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             d_orig,
  input  logic             shift_enable,
  input  logic             eop,
  input  logic             fifo_full,
  output logic             rcving,
  output logic             timer_en,
  output logic             w_enable,
  output logic [7:0]       rx_data,
  output logic             r_error,
  output logic [CNT_W-1:0] byte_count
);
  typedef enum logic [2:0] {IDLE, SYNC, RX, WRITE, EOPW, ERR, ERRW} state_t;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BYTES);
  state_t state_q, state_d;
  logic [7:0] sr_q, sr_d, sr_nx, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, rcv_q, wen_q;
  logic shifting, done, se_eop, se_end;
  always_comb begin
    shifting = shift_enable & ~eop & (state_q inside {SYNC, RX, WRITE});
    sr_nx = {d_orig, sr_q[7:1]};
    done = shifting & (bit_cnt_q == 3'd7);
    se_eop = shift_enable & eop;
    se_end = shift_enable & ~eop;
    sr_d = shifting ? sr_nx : sr_q;
    bit_cnt_d = shifting ? bit_cnt_q + 3'd1 : bit_cnt_q;
    cnt_d = cnt_q;
    rx_data_d = rx_data_q;
    err_d = err_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (d_edge) begin
        state_d = SYNC;
        err_d = 1'b0;
        cnt_d = '0;
        bit_cnt_d = '0;
      end
      SYNC: state_d = done ? (sr_nx == SYNC_BYTE ? RX : ERR) : se_eop ? ERR : SYNC;
      RX: begin
        rx_data_d = done ? sr_nx : rx_data_q;
        state_d = done ? ((fifo_full || cnt_q == MAX_C) ? ERR : WRITE)
                : se_eop ? (bit_cnt_q == 3'd0 ? EOPW : ERR) : RX;
      end
      WRITE: begin
        state_d = RX;
        cnt_d = cnt_q + CNT_W'(1);
      end
      EOPW: state_d = se_end ? IDLE : EOPW;
      ERR: state_d = eop ? ERRW : ERR;
      ERRW: state_d = se_end ? IDLE : ERRW;
      default: state_d = IDLE;
    endcase
    err_d = (state_d == ERR) ? 1'b1 : err_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_cnt_q <= '0;
      cnt_q <= '0;
      rx_data_q <= '0;
      err_q <= 1'b0;
      rcv_q <= 1'b0;
      wen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q <= cnt_d;
      rx_data_q <= rx_data_d;
      err_q <= err_d;
      rcv_q <= state_d != IDLE;
      wen_q <= state_d == WRITE;
    end
  end
  assign rcving = rcv_q;
  assign timer_en = rcv_q;
  assign w_enable = wen_q;
  assign rx_data = rx_data_q;
  assign r_error = err_q;
  assign byte_count = cnt_q;
endmodule

// File: tb/tb_rx_ctrl_unit.sv
// tb_rx_ctrl_unit: directed scoreboard bench for rx_ctrl_unit
module tb_rx_ctrl_unit;
  logic clk = 0, rst = 1, d_edge = 0, d_orig = 0, shift_enable = 0, eop = 0, fifo_full = 0, sel = 0;
  logic rcving, timer_en, w_enable, r_error, rcving2, timer_en2, w_enable2, r_error2;
  logic [7:0] rx_data, rx_data2, e1, e2;
  logic [6:0] byte_count, byte_count2;
  logic [7:0] exp_q[$], exp2_q[$];
  logic [7:0] tbl[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  rx_ctrl_unit u_dut (
    .clk(clk), .rst(rst), .d_edge(d_edge & ~sel), .d_orig(d_orig),
    .shift_enable(shift_enable & ~sel), .eop(eop), .fifo_full(fifo_full),
    .rcving(rcving), .timer_en(timer_en), .w_enable(w_enable), .rx_data(rx_data),
    .r_error(r_error), .byte_count(byte_count)
  );
  rx_ctrl_unit #(.MAX_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .d_edge(d_edge & sel), .d_orig(d_orig),
    .shift_enable(shift_enable & sel), .eop(eop), .fifo_full(fifo_full),
    .rcving(rcving2), .timer_en(timer_en2), .w_enable(w_enable2), .rx_data(rx_data2),
    .r_error(r_error2), .byte_count(byte_count2)
  );
  always @(negedge clk) begin
    if (w_enable) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: rx_data=%h, no write expected", rx_data);
      end else begin
        e1 = exp_q.pop_front();
        if (rx_data !== e1) begin
          n_fail++;
          $display("FAIL wr_data: got %h expected %h", rx_data, e1);
        end
      end
    end
    if (w_enable2) begin
      n_chk++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr2_unexpected: rx_data=%h, no write expected", rx_data2);
      end else begin
        e2 = exp2_q.pop_front();
        if (rx_data2 !== e2) begin
          n_fail++;
          $display("FAIL wr2_data: got %h expected %h", rx_data2, e2);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    d_orig = b;
    shift_enable = 1;
    tick(1);
    shift_enable = 0;
    tick(2);
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask
  task automatic edge_pulse();
    d_edge = 1;
    tick(1);
    d_edge = 0;
    tick(1);
  endtask
  task automatic end_pkt();
    eop = 1;
    send_bit(0);
    tick(2);
    eop = 0;
    send_bit(0);
    tick(2);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rcving"}, rcving, 0);
    chk({tag, "_timer_en"}, timer_en, 0);
    chk({tag, "_w_enable"}, w_enable, 0);
    chk({tag, "_r_error"}, r_error, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_byte_count"}, byte_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end
  initial begin
    tick(3);
    rst = 0;
    tick(1);
    chk_zero("reset");
    edge_pulse();
    chk("t1_rcving", rcving, 1);
    chk("t1_timer_en", timer_en, 1);
    send_byte(8'h80);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    chk("t1_count", byte_count, 2);
    end_pkt();
    chk("t1_rcving_end", rcving, 0);
    chk("t1_timer_end", timer_en, 0);
    chk("t1_r_error", r_error, 0);
    chk("t1_count_end", byte_count, 2);
    chk("t1_rx_data", rx_data, 8'h3C);
    edge_pulse();
    send_byte(8'h81);
    chk("t2_r_error", r_error, 1);
    chk("t2_rcving", rcving, 1);
    end_pkt();
    chk("t2_r_error_idle", r_error, 1);
    chk("t2_rcving_idle", rcving, 0);
    edge_pulse();
    chk("t2_r_error_clr", r_error, 0);
    chk("t2_count_clr", byte_count, 0);
    chk("t2_rcving_new", rcving, 1);
    send_byte(8'h80);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    repeat (3) send_bit(1);
    end_pkt();
    chk("t3_r_error", r_error, 1);
    chk("t3_count", byte_count, 1);
    chk("t3_rcving", rcving, 0);
    chk("t3_rx_data", rx_data, 8'h5A);
    edge_pulse();
    send_byte(8'h80);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(tbl[i]);
      send_byte(tbl[i]);
    end
    fifo_full = 1;
    send_byte(8'hEE);
    fifo_full = 0;
    chk("t4_r_error", r_error, 1);
    chk("t4_rcving", rcving, 1);
    chk("t4_count", byte_count, 10);
    chk("t4_rx_data", rx_data, 8'hEE);
    tick(4);
    chk("t4_err_hold", rcving, 1);
    end_pkt();
    chk("t4_rcving_end", rcving, 0);
    sel = 1;
    edge_pulse();
    send_byte(8'h80);
    exp2_q.push_back(8'h01);
    send_byte(8'h01);
    exp2_q.push_back(8'h02);
    send_byte(8'h02);
    send_byte(8'h03);
    chk("t5_r_error", r_error2, 1);
    chk("t5_count", byte_count2, 2);
    chk("t5_rx_data", rx_data2, 8'h03);
    end_pkt();
    chk("t5_rcving_end", rcving2, 0);
    chk("t5_other_idle", rcving, 0);
    sel = 0;
    edge_pulse();
    send_byte(8'h80);
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_bit(tbl[1][i]);
    edge_pulse();
    chk("t6_rx_edge_rcving", rcving, 1);
    chk("t6_rx_edge_err", r_error, 0);
    chk("t6_rx_edge_count", byte_count, 1);
    for (int i = 4; i < 7; i++) send_bit(tbl[1][i]);
    exp_q.push_back(tbl[1]);
    d_orig = tbl[1][7];
    shift_enable = 1;
    tick(1);
    shift_enable = 0;
    d_edge = 1;
    tick(1);
    d_edge = 0;
    tick(1);
    chk("t6_wr_edge_count", byte_count, 2);
    chk("t6_wr_edge_err", r_error, 0);
    chk("t6_wr_edge_rcving", rcving, 1);
    repeat (3) send_bit(1);
    rst = 1;
    tick(1);
    rst = 0;
    chk_zero("t6_rst");
    tick(30);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb2_drained", exp2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
